// File: rtl/int_sequencer.sv
// Interrupt entry / return-from-interrupt sequencer in front of the fetch stage.
// It drains the pipe, pushes the PC and then the flags, and steers fetch to the vector or return PC.
module int_sequencer #(
   parameter int unsigned PC_W         = 32,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_int_req,
   input  logic [2:0]      i_int_index,
   input  logic            i_stall,
   input  logic            i_branch_pending,
   input  logic            i_rti,
   input  logic [PC_W-1:0] i_pc,
   input  logic [3:0]      i_flags,
   input  logic [PC_W-1:0] i_pop_data,
   output logic            o_fetch_en,
   output logic            o_flush,
   output logic            o_push_valid,
   output logic [PC_W-1:0] o_push_data,
   output logic            o_push_en32,
   output logic            o_pop_valid,
   output logic            o_pop_en32,
   output logic [1:0]      o_pc_select,
   output logic [2:0]      o_ivt_index,
   output logic [PC_W-1:0] o_ret_pc,
   output logic [3:0]      o_flags_restore,
   output logic            o_flags_restore_valid,
   output logic            o_int_ack,
   output logic            o_busy
);

   typedef enum logic [3:0] {
      StIdle, StDrain, StPushPc, StPushFlags, StVector,
      StRtiFlags, StRtiFwait, StRtiPc, StRtiPwait
   } stateT;

   stateT           stateQ, stateD;
   logic            reqQ;
   logic            pendingQ, pendingD;
   logic [2:0]      indexQ, indexD;
   logic [3:0]      cntQ, cntD;
   logic [PC_W-1:0] savedPcQ, savedPcD;
   logic [3:0]      savedFlagsQ, savedFlagsD;

   logic intEdge;
   logic inEntry;
   logic startInt;

   assign intEdge  = i_int_req & ~reqQ;
   assign inEntry  = (stateQ == StDrain) || (stateQ == StPushPc) ||
                     (stateQ == StPushFlags) || (stateQ == StVector);
   assign startInt = (stateQ == StIdle) & pendingQ & ~i_stall & ~i_branch_pending;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ      <= StIdle;
         reqQ        <= 1'b0;
         pendingQ    <= 1'b0;
         indexQ      <= 3'd0;
         cntQ        <= 4'd0;
         savedPcQ    <= '0;
         savedFlagsQ <= 4'd0;
      end else begin
         stateQ      <= stateD;
         reqQ        <= i_int_req;
         pendingQ    <= pendingD;
         indexQ      <= indexD;
         cntQ        <= cntD;
         savedPcQ    <= savedPcD;
         savedFlagsQ <= savedFlagsD;
      end
   end

   always_comb begin
      stateD = stateQ;
      unique case (stateQ)
         StIdle: begin
            // A pending interrupt wins over a simultaneous RTI; the flushed RTI refetches.
            if (startInt)   stateD = StDrain;
            else if (i_rti) stateD = StRtiFlags;
         end
         StDrain:     if (cntQ <= 4'd1) stateD = StPushPc;
         StPushPc:    stateD = StPushFlags;
         StPushFlags: stateD = StVector;
         StVector:    stateD = StIdle;
         StRtiFlags:  stateD = StRtiFwait;
         StRtiFwait:  stateD = StRtiPc;
         StRtiPc:     stateD = StRtiPwait;
         StRtiPwait:  stateD = StIdle;
         default:     stateD = StIdle;
      endcase
   end

   always_comb begin
      pendingD    = pendingQ;
      indexD      = indexQ;
      cntD        = cntQ;
      savedPcD    = savedPcQ;
      savedFlagsD = savedFlagsQ;
      if (stateQ == StVector) begin
         pendingD = 1'b0;
      end else if (intEdge && !pendingQ && !inEntry) begin
         pendingD = 1'b1;
         indexD   = i_int_index;
      end
      if (startInt) begin
         cntD        = 4'(DRAIN_CYCLES);
         savedPcD    = i_pc;
         savedFlagsD = i_flags;
      end else if (stateQ == StDrain) begin
         cntD = cntQ - 4'd1;
      end
   end

   always_comb begin
      o_fetch_en            = 1'b0;
      o_flush               = 1'b0;
      o_push_valid          = 1'b0;
      o_push_data           = '0;
      o_push_en32           = 1'b0;
      o_pop_valid           = 1'b0;
      o_pop_en32            = 1'b0;
      o_pc_select           = 2'b00;
      o_ivt_index           = 3'd0;
      o_ret_pc              = '0;
      o_flags_restore       = 4'd0;
      o_flags_restore_valid = 1'b0;
      o_int_ack             = 1'b0;
      unique case (stateQ)
         StIdle: begin
            o_fetch_en = ~startInt;
            o_flush    = startInt | i_rti;
         end
         StPushPc: begin
            o_push_valid = 1'b1;
            o_push_en32  = 1'b1;
            o_push_data  = savedPcQ;
         end
         StPushFlags: begin
            o_push_valid = 1'b1;
            o_push_data  = {{(PC_W-4){1'b0}}, savedFlagsQ};
         end
         StVector: begin
            o_pc_select = 2'b01;
            o_ivt_index = indexQ;
            o_int_ack   = 1'b1;
            o_fetch_en  = 1'b1;
         end
         StRtiFlags: o_pop_valid = 1'b1;
         StRtiFwait: begin
            o_flags_restore       = i_pop_data[3:0];
            o_flags_restore_valid = 1'b1;
         end
         StRtiPc: begin
            o_pop_valid = 1'b1;
            o_pop_en32  = 1'b1;
         end
         StRtiPwait: begin
            o_ret_pc    = i_pop_data;
            o_pc_select = 2'b10;
            o_fetch_en  = 1'b1;
         end
         default: ;
      endcase
   end

   assign o_busy = (stateQ != StIdle) | pendingQ;

endmodule

// File: tb/tb_int_sequencer.sv
// Directed bench for int_sequencer: interrupt entry, stall deferral, RTI, priority,
// ignored second edge and mid-sequence reset.
module tb_int_sequencer;
   localparam int PC_W = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            i_int_req, i_stall, i_branch_pending, i_rti;
   logic [2:0]      i_int_index;
   logic [PC_W-1:0] i_pc, i_pop_data;
   logic [3:0]      i_flags;
   logic            o_fetch_en, o_flush, o_push_valid, o_push_en32;
   logic            o_pop_valid, o_pop_en32, o_flags_restore_valid, o_int_ack, o_busy;
   logic [PC_W-1:0] o_push_data, o_ret_pc;
   logic [1:0]      o_pc_select;
   logic [2:0]      o_ivt_index;
   logic [3:0]      o_flags_restore;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   int_sequencer #(.PC_W(PC_W), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst), .i_int_req(i_int_req), .i_int_index(i_int_index),
      .i_stall(i_stall), .i_branch_pending(i_branch_pending), .i_rti(i_rti), .i_pc(i_pc),
      .i_flags(i_flags), .i_pop_data(i_pop_data), .o_fetch_en(o_fetch_en), .o_flush(o_flush),
      .o_push_valid(o_push_valid), .o_push_data(o_push_data), .o_push_en32(o_push_en32),
      .o_pop_valid(o_pop_valid), .o_pop_en32(o_pop_en32), .o_pc_select(o_pc_select),
      .o_ivt_index(o_ivt_index), .o_ret_pc(o_ret_pc), .o_flags_restore(o_flags_restore),
      .o_flags_restore_valid(o_flags_restore_valid), .o_int_ack(o_int_ack), .o_busy(o_busy)
   );

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0; i_int_req = 0; i_int_index = 0; i_stall = 0; i_branch_pending = 0;
      i_rti = 0; i_pc = 0; i_flags = 0; i_pop_data = 0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (o_fetch_en !== 1'b1) begin errors++; $display("FAIL reset fetch_en got %b exp 1", o_fetch_en); end
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset flush got %b exp 0", o_flush); end
      checks++; if (o_push_valid !== 1'b0 || o_pop_valid !== 1'b0) begin errors++; $display("FAIL reset push/pop got %b/%b exp 0/0", o_push_valid, o_pop_valid); end
      checks++; if (o_pc_select !== 2'b00 || o_int_ack !== 1'b0) begin errors++; $display("FAIL reset pcsel/ack got %b/%b exp 00/0", o_pc_select, o_int_ack); end
      checks++; if (o_busy !== 1'b0 || o_flags_restore_valid !== 1'b0) begin errors++; $display("FAIL reset busy/frv got %b/%b exp 0/0", o_busy, o_flags_restore_valid); end
      rst = 1'b1;
      nextCycle();
   endtask

   task automatic test_int_basic();
      i_int_req = 1; i_int_index = 3'd5; i_pc = 32'h0000_0040; i_flags = 4'hA;
      @(negedge clk);
      checks++; if (o_flush !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL basic edge-cycle flush/busy got %b/%b exp 0/0", o_flush, o_busy); end
      nextCycle();
      for (int c = 0; c <= 7; c++) begin
         if (c == 1) begin i_pc = 32'hDEAD_BEEF; i_flags = 4'h5; end
         @(negedge clk);
         checks++; if (o_flush !== (c == 0)) begin errors++; $display("FAIL basic flush c=%0d got %b", c, o_flush); end
         checks++; if (o_fetch_en !== (c >= 6)) begin errors++; $display("FAIL basic fetch_en c=%0d got %b", c, o_fetch_en); end
         checks++; if (o_int_ack !== (c == 6)) begin errors++; $display("FAIL basic int_ack c=%0d got %b", c, o_int_ack); end
         checks++; if (o_push_valid !== (c == 4 || c == 5)) begin errors++; $display("FAIL basic push_valid c=%0d got %b", c, o_push_valid); end
         checks++; if (o_busy !== (c < 7)) begin errors++; $display("FAIL basic busy c=%0d got %b", c, o_busy); end
         if (c == 4) begin
            checks++; if (o_push_data !== 32'h40 || o_push_en32 !== 1'b1) begin errors++; $display("FAIL basic push_pc got %h/%b exp 40/1", o_push_data, o_push_en32); end
         end
         if (c == 5) begin
            checks++; if (o_push_data !== 32'hA || o_push_en32 !== 1'b0) begin errors++; $display("FAIL basic push_flags got %h/%b exp a/0", o_push_data, o_push_en32); end
         end
         if (c == 6) begin
            checks++; if (o_pc_select !== 2'b01 || o_ivt_index !== 3'd5) begin errors++; $display("FAIL basic vector got %b/%0d exp 01/5", o_pc_select, o_ivt_index); end
         end
         nextCycle();
      end
      i_int_req = 0;
      nextCycle();
   endtask

   task automatic test_stall();
      i_stall = 1; i_int_req = 1; i_int_index = 3'd6; i_pc = 32'h80; i_flags = 4'h3;
      @(negedge clk);
      checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL stall flush s=0 got %b exp 0", o_flush); end
      for (int s = 1; s <= 3; s++) begin
         nextCycle();
         @(negedge clk);
         checks++; if (o_flush !== 1'b0 || o_fetch_en !== 1'b1) begin errors++; $display("FAIL stall hold s=%0d flush/fetch got %b/%b exp 0/1", s, o_flush, o_fetch_en); end
         checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stall busy s=%0d got %b exp 1", s, o_busy); end
      end
      nextCycle();
      i_stall = 0;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         checks++; if (o_flush !== (c == 0)) begin errors++; $display("FAIL stall flush c=%0d got %b", c, o_flush); end
         checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL stall busy c=%0d got %b exp 1", c, o_busy); end
         checks++; if (o_int_ack !== (c == 6)) begin errors++; $display("FAIL stall int_ack c=%0d got %b", c, o_int_ack); end
         if (c == 4) begin
            checks++; if (o_push_data !== 32'h80) begin errors++; $display("FAIL stall push_pc got %h exp 80", o_push_data); end
         end
         if (c == 6) begin
            checks++; if (o_ivt_index !== 3'd6) begin errors++; $display("FAIL stall ivt got %0d exp 6", o_ivt_index); end
         end
         nextCycle();
      end
      i_int_req = 0;
      nextCycle();
   endtask

   task automatic test_rti();
      i_rti = 1;
      @(negedge clk);
      checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL rti flush got %b exp 1", o_flush); end
      nextCycle();
      i_rti = 0;
      @(negedge clk);
      checks++; if (o_pop_valid !== 1'b1 || o_pop_en32 !== 1'b0 || o_fetch_en !== 1'b0) begin errors++; $display("FAIL rti pop_flags got %b/%b/%b exp 1/0/0", o_pop_valid, o_pop_en32, o_fetch_en); end
      nextCycle();
      i_pop_data = 32'h3;
      @(negedge clk);
      checks++; if (o_flags_restore !== 4'h3 || o_flags_restore_valid !== 1'b1) begin errors++; $display("FAIL rti flags got %h/%b exp 3/1", o_flags_restore, o_flags_restore_valid); end
      nextCycle();
      i_pop_data = 32'h0;
      @(negedge clk);
      checks++; if (o_pop_valid !== 1'b1 || o_pop_en32 !== 1'b1) begin errors++; $display("FAIL rti pop_pc got %b/%b exp 1/1", o_pop_valid, o_pop_en32); end
      nextCycle();
      i_pop_data = 32'h0000_1234;
      @(negedge clk);
      checks++; if (o_pc_select !== 2'b10 || o_ret_pc !== 32'h1234 || o_fetch_en !== 1'b1) begin errors++; $display("FAIL rti return got %b/%h/%b exp 10/1234/1", o_pc_select, o_ret_pc, o_fetch_en); end
      nextCycle();
      i_pop_data = 32'h0;
      @(negedge clk);
      checks++; if (o_pc_select !== 2'b00 || o_busy !== 1'b0) begin errors++; $display("FAIL rti idle got %b/%b exp 00/0", o_pc_select, o_busy); end
      nextCycle();
   endtask

   task automatic test_rti_vs_int();
      int pops = 0;
      i_int_req = 1; i_int_index = 3'd1;
      nextCycle();
      i_rti = 1;
      @(negedge clk);
      checks++; if (o_flush !== 1'b1 || o_fetch_en !== 1'b0) begin errors++; $display("FAIL prio entry flush/fetch got %b/%b exp 1/0", o_flush, o_fetch_en); end
      nextCycle();
      i_rti = 0;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         if (o_pop_valid === 1'b1 || o_pc_select === 2'b10) pops++;
         if (c == 6) begin
            checks++; if (o_int_ack !== 1'b1 || o_ivt_index !== 3'd1) begin errors++; $display("FAIL prio ack/ivt got %b/%0d exp 1/1", o_int_ack, o_ivt_index); end
         end
         nextCycle();
      end
      checks++; if (pops !== 0) begin errors++; $display("FAIL prio pop cycles got %0d exp 0", pops); end
      i_int_req = 0;
      nextCycle();
   endtask

   task automatic test_edge_in_drain();
      int acks = 0;
      i_int_req = 1; i_int_index = 3'd5;
      nextCycle();
      for (int c = 0; c <= 10; c++) begin
         if (c == 1) i_int_req = 0;
         if (c == 2) begin i_int_req = 1; i_int_index = 3'd2; end
         if (c == 3) i_int_req = 0;
         @(negedge clk);
         if (o_int_ack === 1'b1) acks++;
         if (c == 6) begin
            checks++; if (o_ivt_index !== 3'd5) begin errors++; $display("FAIL drain2 ivt got %0d exp 5", o_ivt_index); end
         end
         if (c == 8) begin
            checks++; if (o_busy !== 1'b0 || o_flush !== 1'b0) begin errors++; $display("FAIL drain2 idle busy/flush got %b/%b exp 0/0", o_busy, o_flush); end
         end
         nextCycle();
      end
      checks++; if (acks !== 1) begin errors++; $display("FAIL drain2 ack count got %0d exp 1", acks); end
   endtask

   task automatic test_reset_mid();
      i_int_req = 1; i_int_index = 3'd4; i_pc = 32'h100; i_flags = 4'h7;
      nextCycle();
      for (int c = 0; c < 5; c++) begin
         if (c == 1) i_int_req = 0;
         nextCycle();
      end
      #2;
      checks++; if (o_push_valid !== 1'b1 || o_push_data !== 32'h7) begin errors++; $display("FAIL rstmid pre push got %b/%h exp 1/7", o_push_valid, o_push_data); end
      rst = 1'b0;
      #1;
      checks++; if (o_fetch_en !== 1'b1 || o_push_valid !== 1'b0 || o_push_data !== 32'h0) begin errors++; $display("FAIL rstmid outputs got %b/%b/%h exp 1/0/0", o_fetch_en, o_push_valid, o_push_data); end
      checks++; if (o_busy !== 1'b0 || o_int_ack !== 1'b0) begin errors++; $display("FAIL rstmid busy/ack got %b/%b exp 0/0", o_busy, o_int_ack); end
      nextCycle();
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         nextCycle();
         @(negedge clk);
         checks++; if (o_busy !== 1'b0 || o_flush !== 1'b0 || o_fetch_en !== 1'b1) begin errors++; $display("FAIL rstmid after c=%0d busy/flush/fetch got %b/%b/%b exp 0/0/1", c, o_busy, o_flush, o_fetch_en); end
      end
   endtask

   initial begin
      test_reset();
      test_int_basic();
      test_stall();
      test_rti();
      test_rti_vs_int();
      test_edge_in_drain();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
